// File: rtl/renorm_precarry.sv
// renorm_precarry: AV1 encoder range renormalisation with pre-carry symbol emission.
// Shifts range/low by the leading-zero count and queues 9-bit pre-carry symbols in a small FIFO.
module renorm_precarry #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 4,
  parameter int LOW_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RANGE_WIDTH-1:0] in_range,
  input  logic [D_SIZE-1:0]      in_lzc,
  input  logic                   in_v,
  input  logic [RANGE_WIDTH-1:0] in_low_inc,
  input  logic                   in_flush,
  output logic [RANGE_WIDTH-1:0] out_range,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8:0]             out_sym,
  output logic                   flush_done,
  output logic                   err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(FIFO_DEPTH - 2);
  localparam logic signed [5:0] CNT_INIT = -6'sd9;

  function automatic logic [LOW_WIDTH-1:0] low_mask(input logic [5:0] sh);
    low_mask = (LOW_WIDTH'(1) << sh) - LOW_WIDTH'(1);
  endfunction

  // Round low up to a 2^14 boundary and set the terminating bit.
  function automatic logic [LOW_WIDTH-1:0] flush_round(input logic [LOW_WIDTH-1:0] low);
    flush_round = ((low + LOW_WIDTH'('h3FFF)) & ~LOW_WIDTH'('h3FFF)) | LOW_WIDTH'('h4000);
  endfunction

  logic [LOW_WIDTH-1:0]   low_p1;
  logic signed [5:0]      cnt_p1;
  logic [RANGE_WIDTH-1:0] range_p1;
  logic                   err_p1;
  logic                   flush_vld_p1;

  logic [8:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nx;
  logic [PTR_W:0]   occ, occ_nx;

  logic do_req, do_err, do_flush, pop;

  logic [LOW_WIDTH-1:0] lsum, l_fin, m, low_req;
  logic signed [5:0]    d_x, s_x, c_x, s_fin;
  logic [1:0]           req_n;
  logic [8:0]           req_s0, req_s1;

  logic [LOW_WIDTH-1:0] e0, e1;
  logic signed [5:0]    fc_x, fc2_x, fs_x;
  logic [1:0]           fl_n;
  logic [8:0]           fl_s0, fl_s1;

  logic [1:0] n_push;
  logic [8:0] push0, push1;

  assign in_ready  = (occ <= READY_MAX);
  assign out_valid = (occ != '0);
  assign out_sym   = out_valid ? mem[rd_ptr] : 9'd0;
  assign out_range = range_p1;
  assign err       = err_p1;
  assign flush_done = flush_vld_p1;

  assign do_req   = in_valid & in_ready & in_v;
  assign do_err   = in_valid & in_ready & ~in_v;
  assign do_flush = in_ready & in_flush & ~in_valid;
  assign pop      = out_valid & out_ready;

  // Request path: add increment, emit up to two bytes, renormalise.
  always_comb begin
    d_x    = 6'(in_lzc);
    lsum   = low_p1 + LOW_WIDTH'(in_low_inc);
    s_x    = cnt_p1 + d_x;
    c_x    = cnt_p1 + 6'sd16;
    m      = low_mask(c_x);
    l_fin  = lsum;
    s_fin  = s_x;
    req_n  = 2'd0;
    req_s0 = '0;
    req_s1 = '0;
    if (!s_x[5]) begin
      if (s_x >= 6'sd8) begin
        req_s0 = 9'(lsum >> c_x);
        l_fin  = lsum & m;
        c_x    = c_x - 6'sd8;
        m      = m >> 8;
        req_s1 = 9'(l_fin >> c_x);
        l_fin  = l_fin & m;
        req_n  = 2'd2;
      end else begin
        req_s0 = 9'(lsum >> c_x);
        l_fin  = lsum & m;
        req_n  = 2'd1;
      end
      s_fin = c_x + d_x - 6'sd24;
    end
    low_req = l_fin << in_lzc;
  end

  // Flush path: cnt never drops below -9, so at most two symbols.
  always_comb begin
    e0    = flush_round(low_p1);
    fc_x  = cnt_p1 + 6'sd16;
    fc2_x = fc_x - 6'sd8;
    fs_x  = cnt_p1 + 6'sd10;
    fl_s0 = 9'(e0 >> fc_x);
    e1    = e0 & low_mask(fc_x);
    fl_s1 = 9'(e1 >> fc2_x);
    fl_n  = 2'd0;
    if (fs_x > 6'sd8)      fl_n = 2'd2;
    else if (fs_x > 6'sd0) fl_n = 2'd1;
  end

  always_comb begin
    n_push = 2'd0;
    push0  = '0;
    push1  = '0;
    if (do_req) begin
      n_push = req_n;
      push0  = req_s0;
      push1  = req_s1;
    end else if (do_flush) begin
      n_push = fl_n;
      push0  = fl_s0;
      push1  = fl_s1;
    end
  end

  assign wr_ptr_nx = wr_ptr + 1'b1;
  assign occ_nx    = occ + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);

  // Stage p1: encoder state, FIFO pointers and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      low_p1       <= '0;
      cnt_p1       <= CNT_INIT;
      range_p1     <= '0;
      err_p1       <= 1'b0;
      flush_vld_p1 <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
    end else begin
      flush_vld_p1 <= do_flush;
      if (do_req) begin
        low_p1   <= low_req;
        cnt_p1   <= s_fin;
        range_p1 <= in_range << in_lzc;
      end else if (do_flush) begin
        low_p1 <= '0;
        cnt_p1 <= CNT_INIT;
      end
      if (do_err) err_p1 <= 1'b1;
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      occ    <= occ_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr]    <= push0;
    if (n_push == 2'd2) mem[wr_ptr_nx] <= push1;
  end
endmodule

// File: tb/tb_renorm_precarry.sv
// Bench for renorm_precarry: directed scenarios plus randomized traffic against a
// behavioural model of the encoder state and an expected-symbol queue.
module tb_renorm_precarry;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_v = 1'b1, in_flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_range = 16'h8000, in_low_inc = 16'h0;
  logic [3:0]  in_lzc = 4'd0;
  logic in_ready, out_valid, flush_done, err;
  logic [15:0] out_range;
  logic [8:0]  out_sym;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] low_m;
  int          cnt_m;
  int          range_m;
  bit          err_m, fd_m;
  logic [8:0]  exp_q[$];
  bit          last_acc_req;

  always #5 clk = ~clk;

  renorm_precarry dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_range(in_range), .in_lzc(in_lzc), .in_v(in_v), .in_low_inc(in_low_inc),
    .in_flush(in_flush),
    .out_range(out_range), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .flush_done(flush_done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int lzc16(input int r);
    for (int i = 15; i >= 0; i--) if (r[i]) return 15 - i;
    return 16;
  endfunction

  task automatic model_reset();
    low_m = 0; cnt_m = -9; range_m = 0; err_m = 0; fd_m = 0;
    exp_q.delete();
  endtask

  // Range/low normalisation written straight from the arithmetic rules.
  task automatic model_req(input int rng, input int d, input int inc);
    logic [63:0] L, m;
    int s, c;
    L = low_m + 64'(inc);
    s = cnt_m + d;
    if (s >= 0) begin
      c = cnt_m + 16;
      m = (64'd1 << c) - 1;
      if (s >= 8) begin
        exp_q.push_back(9'(L >> c));
        L = L & m; c = c - 8; m = m >> 8;
      end
      exp_q.push_back(9'(L >> c));
      L = L & m;
      s = c + d - 24;
    end
    low_m   = (L << d) & 64'hFFFF_FFFF;
    cnt_m   = s;
    range_m = (rng << d) & 32'hFFFF;
  endtask

  task automatic model_flush();
    logic [63:0] e;
    int c, s;
    e = ((low_m + 64'h3FFF) & ~64'h3FFF) | 64'h4000;
    c = cnt_m;
    s = c + 10;
    while (s > 0) begin
      exp_q.push_back(9'(e >> (c + 16)));
      e = e & ((64'd1 << (c + 16)) - 1);
      c = c - 8;
      s = s - 8;
    end
    low_m = 0;
    cnt_m = -9;
  endtask

  task automatic drive(input bit v, input int rng, input bit vflag, input int inc,
                       input bit fl, input bit ordy);
    in_valid   = v;
    in_range   = 16'(rng);
    in_lzc     = 4'(lzc16(rng));
    in_v       = vflag;
    in_low_inc = 16'(inc);
    in_flush   = fl;
    out_ready  = ordy;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model past the rising edge.
  task automatic step();
    bit exp_rdy, acc_req, acc_fl, do_pop, v_s;
    int r_s, d_s, inc_s;
    @(negedge clk);
    exp_rdy = (FIFO_DEPTH - exp_q.size()) >= 2;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_sym", out_sym, exp_q[0]);
    check("out_range", out_range, range_m);
    check("err", err, err_m);
    check("flush_done", flush_done, fd_m);
    acc_req = in_valid && exp_rdy;
    acc_fl  = exp_rdy && in_flush && !in_valid;
    do_pop  = (exp_q.size() != 0) && out_ready;
    r_s = in_range; d_s = in_lzc; inc_s = in_low_inc; v_s = in_v;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
      acc_req = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      fd_m = acc_fl;
      if (acc_req) begin
        if (v_s) model_req(r_s, d_s, inc_s);
        else     err_m = 1;
      end else if (acc_fl) begin
        model_flush();
      end
    end
    last_acc_req = acc_req;
  endtask

  task automatic idle(input bit ordy);
    drive(0, 16'h8000, 1, 0, 0, ordy);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(0);
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    bit seen;
    int r;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 0);
    check("rst_err", err, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_out_range", out_range, 0);
    reset = 1'b1;

    // Smallest range: one zero symbol, cnt -2 shows up in the following flush.
    drive(1, 16'h0001, 1, 0, 0, 0); step();
    check("tp1_valid", out_valid, 1);
    check("tp1_sym", out_sym, 9'h000);
    check("tp1_range", out_range, 16'h8000);
    idle(1); step();
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("tp1_flush_done", flush_done, 1);
    check("tp1_flush_sym", out_sym, 9'h001);
    idle(1); step(); step();

    // Low accumulation then emission, flush, and post-flush state.
    do_reset();
    drive(1, 16'h8000, 1, 16'h7FFF, 0, 0); step();
    check("tp2a_valid", out_valid, 0);
    check("tp2a_range", out_range, 16'h8000);
    drive(1, 16'h0001, 1, 0, 0, 0); step();
    check("tp2b_valid", out_valid, 1);
    check("tp2b_sym", out_sym, 9'h0FF);
    idle(1); step();
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("tp2c_done", flush_done, 1);
    check("tp2c_sym", out_sym, 9'h0FF);
    idle(1); step();
    check("tp2c_done_pulse", flush_done, 0);
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("tp2d_sym_after_flush", out_sym, 9'h080);
    idle(1); step();

    // Flush straight from reset.
    do_reset();
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("tp3_done", flush_done, 1);
    check("tp3_valid", out_valid, 1);
    check("tp3_sym", out_sym, 9'h080);
    idle(1); step(); step();

    // Two symbols from one request: cnt -2, low 0xFFFF, d 15.
    do_reset();
    drive(1, 16'h0001, 1, 0, 0, 1); step();
    drive(1, 16'hFFFF, 1, 16'h8000, 0, 1); step();
    drive(1, 16'hFFFF, 1, 16'h7FFF, 0, 1); step();
    idle(1); step();
    drive(1, 16'h0001, 1, 0, 0, 0); step();
    check("tp4_sym0", out_sym, 9'h003);
    idle(1); step();
    check("tp4_sym1", out_sym, 9'h0FF);
    step();
    check("tp4_empty", out_valid, 0);
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("tp4_flush_sym", out_sym, 9'h0FE);
    idle(1); step();

    // Backpressure, then a request and a flush raised together.
    do_reset();
    drive(1, 16'h8000, 1, 16'h7FFF, 0, 0); step();
    drive(1, 16'h0003, 1, 2, 0, 0); step();
    check("bp_sym_carry", out_sym, 9'h100);
    drive(1, 16'h0003, 1, 1, 0, 0); step();
    check("bp_in_ready_low", in_ready, 0);
    drive(1, 16'h0003, 1, 2, 0, 0); step();
    check("bp_head_kept", out_sym, 9'h100);
    drive(1, 16'h0003, 1, 2, 1, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = last_acc_req;
    end
    check("bp_req_accept", seen, 1);
    drive(0, 16'h8000, 1, 0, 1, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (flush_done === 1'b1);
    end
    check("bp_flush_seen", seen, 1);
    idle(1);
    repeat (5) step();

    // Invalid request sets err and leaves state untouched.
    do_reset();
    drive(1, 16'h8000, 1, 16'h7FFF, 0, 1); step();
    drive(1, 0, 0, 0, 0, 1); step();
    check("err_set", err, 1);
    check("err_range_kept", out_range, 16'h8000);
    drive(0, 16'h8000, 1, 0, 1, 0); step();
    check("err_state_kept", out_sym, 9'h180);
    idle(1); step();
    check("err_sticky", err, 1);

    // Reset in the middle of traffic.
    drive(1, 16'h0001, 1, 0, 0, 0); step();
    drive(1, 16'h0001, 1, 0, 0, 0); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_range", out_range, 0);
    idle(1); step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      if (r == 0) r = 1;
      drive($urandom_range(0, 9) < 7, r, 1, int'($urandom_range(0, r - 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      step();
    end
    idle(1);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
